regfile_access_ctrl: RTL
========================

// Module: regfile_access_ctrl
// PURPOSE
//  Initiator side of the regfile operand/writeback protocol. Accepts one decoded instruction
//  (rs1/rs2/rd/imm) via valid/ready and issues the register-file address phase. Streams
//  operand A then operand B to the ALU over rs_data_mux/rs_store, waits for alu_data_valid,
//  then commits the writeback (rd_wr_en) and closes with op_done. Sits between decode and regfile/ALU.
// PARAMETERS
//  BUS_WIDTH       32  data width of rs_data, rs_data_mux, imme_data, alu_data_out
//  ADDR_WIDTH      15  packed address width; localparam RA=ADDR_WIDTH/3 (5) per register field
//  TIMEOUT_CYCLES  16  ALU wait limit; used only with REGFILE_CTRL_TIMEOUT_EN
// PORTS
//  clk             in   1          single clock, all logic on posedge
//  rst             in   1          asynchronous, active-high reset
//  instr_valid     in   1          decoded instruction available
//  instr_ready     out  1          controller idle, accepts instruction
//  instr_rs1       in   RA         source register 1 index
//  instr_rs2       in   RA         source register 2 index
//  instr_rd        in   RA         destination register index
//  instr_imm       in   BUS_WIDTH  immediate value
//  instr_use_imm   in   1          1: operand B = imm, 0: operand B = R[rs2]
//  instr_wb        in   1          1: instruction writes rd
//  rs_addr_valid   out  1          one-cycle address strobe to regfile
//  rs1_rs2_rd      out  ADDR_WIDTH {rs1[14:10], rs2[9:5], rd[4:0]}
//  rs_data         in   BUS_WIDTH  regfile read data (R[rs1] at T2, R[rs2] at T3)
//  rs_store        out  1          operand strobe to ALU (1st = A, 2nd = B)
//  rs_data_mux     out  BUS_WIDTH  operand bus to ALU
//  imme_data       out  BUS_WIDTH  captured immediate, held for the whole op
//  alu_data_valid  in   1          ALU result ready (one-cycle pulse)
//  alu_data_out    in   BUS_WIDTH  ALU result
//  rd_wr_en        out  1          writeback strobe to regfile (writes alu result to rd)
//  op_done         out  1          one-cycle end-of-operation pulse
//  wb_data         out  BUS_WIDTH  last captured ALU result
//  timeout_err     out  1          present only with REGFILE_CTRL_TIMEOUT_EN
// BEHAVIOUR
//  - Reset: FSM=IDLE. instr_ready=1; all other outputs 0 (incl. wb_data, timeout_err).
//    Reset mid-op aborts with no rd_wr_en and no op_done.
//  - All outputs registered. FSM: IDLE->ADDR->RS1->RS2->OPB->WAIT_ALU->WB->IDLE.
//  - T0, IDLE, instr_valid&instr_ready: capture all fields. ready drops next cycle.
//  - T1 ADDR: rs_addr_valid=1, rs1_rs2_rd=packed fields, imme_data=imm.
//    rs1_rs2_rd and imme_data are held through WB and return to 0 in IDLE.
//  - T2 RS1: sample rs_data as R[rs1] (regfile read latency 1 after strobe).
//  - T3 RS2: sample rs_data as R[rs2]; drive rs_store=1, rs_data_mux=R[rs1].
//  - T4 OPB: rs_store=1, rs_data_mux = use_imm ? imm : R[rs2].
//  - T5+ WAIT_ALU: rs_store=0, rs_data_mux holds. Wait for alu_data_valid.
//    alu_data_valid outside WAIT_ALU is ignored.
//  - On alu_data_valid (incl. T5): wb_data<=alu_data_out; next cycle WB.
//  - WB (1 cycle): op_done=1; rd_wr_en=1 only if wb && rd!=0 (x0 never written). Then IDLE.
//  - Minimum op is 7 cycles, T0..T6. instr_ready=1 only in IDLE, so an instr arriving in WB waits 1 cycle.
//  - instr_valid while busy: not accepted, no state disturbed; ready re-asserts in IDLE.
// CONFIGURATION
//  REGFILE_CTRL_TIMEOUT_EN defined:
//    - 8-bit wait counter clears on entry to WAIT_ALU and counts each cycle there.
//    - At count==TIMEOUT_CYCLES with no alu_data_valid: go to WB with op_done=1, rd_wr_en=0,
//      timeout_err=1 (same cycle, 1 cycle); wb_data unchanged.
//    - If valid and timeout coincide, valid wins and no error is raised.
//  Not defined: WAIT_ALU waits indefinitely; no counter and no timeout_err port.
// TESTING
//  - Reset: rst=1 mid-WAIT_ALU -> all outputs 0, instr_ready=1, no rd_wr_en/op_done after release.
//  - R-type: rs1=3 (R=0x11), rs2=4 (R=0x22), rd=5, use_imm=0, wb=1; ALU 0x33 at T5 ->
//    rs1_rs2_rd=0x0C85 from T1; rs_store T3 (0x11), T4 (0x22); T6 rd_wr_en=1, op_done=1, wb_data=0x33.
//  - I-type: rs1=1 (R=0x10), imm=0xFFFFFFFF, use_imm=1, rd=2 -> T4 rs_data_mux=0xFFFFFFFF,
//    imme_data held 0xFFFFFFFF until op_done.
//  - x0 dest: rd=0, wb=1, ALU 0x55 -> op_done=1, rd_wr_en stays 0, wb_data=0x55.
//  - Backpressure: instr_valid held high during op; ALU 3 cycles late -> second instr accepted
//    only in IDLE after op_done, never earlier.
//  - Timeout (macro on, TIMEOUT_CYCLES=16): no alu_data_valid ->
//    op_done=1, timeout_err=1, rd_wr_en=0 in WB, then IDLE.

Source files
------------

// File: rtl/regfile_access_ctrl_if.sv
// Operand/writeback bus between regfile_access_ctrl (master) and the
// decode/regfile/ALU side (slave).
interface regfile_access_ctrl_if #(
  parameter int BUS_WIDTH  = 32,
  parameter int ADDR_WIDTH = 15
);
  localparam int RA = ADDR_WIDTH / 3;

  logic                  instr_valid;
  logic                  instr_ready;
  logic [RA-1:0]         instr_rs1;
  logic [RA-1:0]         instr_rs2;
  logic [RA-1:0]         instr_rd;
  logic [BUS_WIDTH-1:0]  instr_imm;
  logic                  instr_use_imm;
  logic                  instr_wb;
  logic                  rs_addr_valid;
  logic [ADDR_WIDTH-1:0] rs1_rs2_rd;
  logic [BUS_WIDTH-1:0]  rs_data;
  logic                  rs_store;
  logic [BUS_WIDTH-1:0]  rs_data_mux;
  logic [BUS_WIDTH-1:0]  imme_data;
  logic                  alu_data_valid;
  logic [BUS_WIDTH-1:0]  alu_data_out;
  logic                  rd_wr_en;
  logic                  op_done;
  logic [BUS_WIDTH-1:0]  wb_data;

  modport master (
    input  instr_valid, instr_rs1, instr_rs2, instr_rd, instr_imm, instr_use_imm, instr_wb,
    input  rs_data, alu_data_valid, alu_data_out,
    output instr_ready, rs_addr_valid, rs1_rs2_rd, rs_store, rs_data_mux, imme_data,
    output rd_wr_en, op_done, wb_data
  );

  modport slave (
    output instr_valid, instr_rs1, instr_rs2, instr_rd, instr_imm, instr_use_imm, instr_wb,
    output rs_data, alu_data_valid, alu_data_out,
    input  instr_ready, rs_addr_valid, rs1_rs2_rd, rs_store, rs_data_mux, imme_data,
    input  rd_wr_en, op_done, wb_data
  );
endinterface

// File: rtl/regfile_access_ctrl.sv
// Regfile operand/writeback sequencer: address phase, operand A/B streaming, ALU wait, writeback.
// Optional ALU wait timeout with timeout_err output when REGFILE_CTRL_TIMEOUT_EN is defined.
module regfile_access_ctrl #(
  parameter int BUS_WIDTH      = 32,
  parameter int ADDR_WIDTH     = 15,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  regfile_access_ctrl_if.master  bus
`ifdef REGFILE_CTRL_TIMEOUT_EN
  ,
  output logic                   timeout_err
`endif
);
  localparam int RA = ADDR_WIDTH / 3;

  if ((ADDR_WIDTH % 3) != 0 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_chk
    $error("regfile_access_ctrl: ADDR_WIDTH must split into 3 fields, TIMEOUT_CYCLES in 1..255");
  end

  typedef enum logic [2:0] {
    IDLE, ADDR, RS1, RS2, OPB, WAIT_ALU, WB
  } state_t;

  state_t        state, state_d;
  logic [RA-1:0] rd_q;
  logic          use_imm_q;
  logic          wb_q;
  logic          accept;
  logic          timeout_hit;

  function automatic logic [ADDR_WIDTH-1:0] pack_addr(input logic [RA-1:0] rs1,
                                                      input logic [RA-1:0] rs2,
                                                      input logic [RA-1:0] rd);
    return ADDR_WIDTH'({rs1, rs2, rd});
  endfunction

  assign accept = (state == IDLE) && bus.instr_valid;

`ifdef REGFILE_CTRL_TIMEOUT_EN
  logic [7:0] wait_cnt;

  // Counter reads 0 in the first WAIT_ALU cycle and advances once per cycle spent there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state == OPB) begin
      wait_cnt <= '0;
    end else if (state == WAIT_ALU) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // A result arriving on the limit cycle takes priority over the timeout.
  assign timeout_hit = (state == WAIT_ALU) && !bus.alu_data_valid &&
                       (wait_cnt == 8'(TIMEOUT_CYCLES));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:     if (bus.instr_valid) state_d = ADDR;
      ADDR:     state_d = RS1;
      RS1:      state_d = RS2;
      RS2:      state_d = OPB;
      OPB:      state_d = WAIT_ALU;
      WAIT_ALU: if (bus.alu_data_valid || timeout_hit) state_d = WB;
      WB:       state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Control outputs are decoded from the next state so each one is a clean register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.instr_ready   <= 1'b1;
      bus.rs_addr_valid <= 1'b0;
      bus.rs_store      <= 1'b0;
      bus.op_done       <= 1'b0;
      bus.rd_wr_en      <= 1'b0;
    end else begin
      bus.instr_ready   <= (state_d == IDLE);
      bus.rs_addr_valid <= (state_d == ADDR);
      bus.rs_store      <= (state_d == RS2) || (state_d == OPB);
      bus.op_done       <= (state_d == WB);
      bus.rd_wr_en      <= (state_d == WB) && wb_q && (rd_q != '0) && !timeout_hit;
    end
  end

`ifdef REGFILE_CTRL_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) timeout_err <= 1'b0;
    else     timeout_err <= (state_d == WB) && timeout_hit;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q            <= '0;
      use_imm_q       <= 1'b0;
      wb_q            <= 1'b0;
      bus.rs1_rs2_rd  <= '0;
      bus.imme_data   <= '0;
      bus.rs_data_mux <= '0;
      bus.wb_data     <= '0;
    end else begin
      if (accept) begin
        rd_q           <= bus.instr_rd;
        use_imm_q      <= bus.instr_use_imm;
        wb_q           <= bus.instr_wb;
        bus.rs1_rs2_rd <= pack_addr(bus.instr_rs1, bus.instr_rs2, bus.instr_rd);
        bus.imme_data  <= bus.instr_imm;
      end else if (state_d == IDLE) begin
        bus.rs1_rs2_rd <= '0;
        bus.imme_data  <= '0;
      end

      // Regfile returns R[rs1] during RS1 and R[rs2] during RS2 (one cycle after the strobe).
      case (state)
        RS1:     bus.rs_data_mux <= bus.rs_data;
        RS2:     bus.rs_data_mux <= use_imm_q ? bus.imme_data : bus.rs_data;
        WB:      bus.rs_data_mux <= '0;
        default: ;
      endcase

      if ((state == WAIT_ALU) && bus.alu_data_valid) bus.wb_data <= bus.alu_data_out;
    end
  end
endmodule
